// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg -- shared definitions for the bit-serial subtractor.
//   SUB_WIDTH_DEF : default operand/result width
//   sub_state_e   : controller states (IDLE, RUN, DONE)
//   cnt_width()   : bit counter width able to hold 0..w without wrapping
package serial_sub_pkg;

  localparam int SUB_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sub_state_e;

  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/full_sub_gate.sv
// full_sub_gate -- one-bit full subtractor (combinational).
//   a, b  : minuend / subtrahend bits
//   bin   : borrow in from the less significant bit
//   diff  : a - b - bin (mod 2)
//   bout  : borrow out to the next bit
module full_sub_gate (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic bout
);

  assign diff = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor -- bit-serial unsigned subtractor, LSB first, one bit per clock.
//   clk, rst    : rising-edge clock, asynchronous active-high reset
//   start       : begin an operation (accepted in IDLE or DONE only)
//   a, b        : operands, captured on the accepting edge
//   busy        : high while bits are being processed (RUN)
//   done        : one-cycle pulse, diff/borrow_out freshly updated
//   diff        : a - b mod 2^WIDTH, held between operations
//   borrow_out  : 1 iff a < b
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = SUB_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int            CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  sub_state_e       r_state, w_next;
  logic [WIDTH-1:0] r_a, r_b, r_res, r_diff;
  logic             r_borrow, r_bout;
  logic [CW-1:0]    r_cnt;
  logic             w_d, w_bo, w_accept, w_last;

  full_sub_gate u_fs (
    .a    (r_a[0]),
    .b    (r_b[0]),
    .bin  (r_borrow),
    .diff (w_d),
    .bout (w_bo)
  );

  assign w_accept = start && (r_state != RUN);
  // Counter holds the index of the bit being processed; LAST marks the final edge.
  assign w_last   = (r_state == RUN) && (r_cnt == LAST);

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = RUN;
      RUN:     if (r_cnt == LAST) w_next = DONE;
      DONE:    w_next = start ? RUN : IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_res    <= '0;
      r_borrow <= 1'b0;
      r_cnt    <= '0;
      r_diff   <= '0;
      r_bout   <= 1'b0;
    end else if (w_accept) begin
      r_a      <= a;
      r_b      <= b;
      r_res    <= '0;
      r_borrow <= 1'b0;
      r_cnt    <= '0;
    end else if (r_state == RUN) begin
      // Result fills from the MSB side so after WIDTH shifts bit 0 sits at LSB.
      r_res    <= {w_d, r_res[WIDTH-1:1]};
      r_a      <= r_a >> 1;
      r_b      <= r_b >> 1;
      r_borrow <= w_bo;
      r_cnt    <= r_cnt + 1'b1;
      if (w_last) begin
        r_diff <= {w_d, r_res[WIDTH-1:1]};
        r_bout <= w_bo;
      end
    end
  end

  assign busy       = (r_state == RUN);
  assign done       = (r_state == DONE);
  assign diff       = r_diff;
  assign borrow_out = r_bout;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor -- directed scoreboard bench for serial_subtractor, WIDTH=8.
module tb_serial_subtractor;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] diff;
    logic         borrow;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a, b;
  logic         busy, done;
  logic [W-1:0] diff;
  logic         borrow_out;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge: present operands, push the reference result, release start
  // one negedge later (just after the accepting edge).
  task automatic launch(input logic [W-1:0] ia, input logic [W-1:0] ib);
    exp_t e;
    logic [W:0] full;
    full     = {1'b0, ia} - {1'b0, ib};
    e.diff   = full[W-1:0];
    e.borrow = (ia < ib);
    q.push_back(e);
    start = 1'b1; a = ia; b = ib;
    @(negedge clk);
    start = 1'b0; a = 'x; b = 'x;
  endtask

  // Called at the negedge after the accepting edge. Optionally fires an extra
  // start (operands 1,1) 'ign' cycles in, which must have no effect.
  task automatic collect(input string tag, input int ign, output int bcnt);
    exp_t e;
    int   cyc;
    cyc  = 0;
    bcnt = busy ? 1 : 0;
    while (!done && cyc < 20) begin
      @(negedge clk);
      cyc++;
      chk({tag, "_busy_done_excl"}, busy & done, 0);
      if (!done && busy) bcnt++;
      if (ign > 0 && cyc == ign) begin
        start = 1'b1; a = 8'h01; b = 8'h01;
      end else if (ign > 0 && cyc == ign + 1) begin
        start = 1'b0; a = 'x; b = 'x;
      end
    end
    chk({tag, "_done_seen"}, done, 1);
    chk({tag, "_latency"}, cyc, W);
    chk({tag, "_sb_nonempty"}, q.size() != 0, 1);
    if (q.size() != 0) begin
      e = q.pop_front();
      chk({tag, "_diff"}, diff, e.diff);
      chk({tag, "_borrow"}, borrow_out, e.borrow);
    end
  endtask

  // Step one cycle past DONE and confirm the pulse was single-cycle.
  task automatic settle(input string tag);
    @(negedge clk);
    chk({tag, "_done_pulse_1cyc"}, done, 0);
    chk({tag, "_idle_not_busy"}, busy, 0);
  endtask

  initial begin
    int bc;
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_diff", diff, 0);
    chk("rst_borrow", borrow_out, 0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);

    // Basic
    launch(8'h5A, 8'h3C); collect("basic", 0, bc); settle("basic");
    // Underflow
    launch(8'h10, 8'h20); collect("uflow1", 0, bc); settle("uflow1");
    launch(8'h00, 8'h01); collect("uflow2", 0, bc); settle("uflow2");
    // Equal operands, busy must span exactly W cycles
    launch(8'hFF, 8'hFF); collect("equal", 0, bc);
    chk("equal_busy_cycles", bc, W);
    settle("equal");

    // Ignored start mid-run: only one result, no second done
    launch(8'h5A, 8'h3C); collect("ignore", 3, bc); settle("ignore");
    repeat (12) begin
      @(negedge clk);
      chk("ignore_no_extra_done", done, 0);
    end
    chk("ignore_sb_empty", q.size(), 0);

    // Back-to-back: new start presented during the DONE cycle
    launch(8'h5A, 8'h3C); collect("b2b_first", 0, bc);
    launch(8'h80, 8'h01);
    chk("b2b_no_idle_gap", busy, 1);
    collect("b2b_second", 0, bc); settle("b2b_second");

    // Mid-operation reset
    launch(8'hA5, 8'h0F);
    void'(q.pop_back());               // aborted, no result expected
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_diff", diff, 0);
    chk("midrst_borrow", borrow_out, 0);
    @(negedge clk);
    start = 1'b1; a = 8'h22; b = 8'h11;  // must be ignored while in reset
    @(negedge clk);
    start = 1'b0; rst = 1'b0;
    repeat (12) begin
      @(negedge clk);
      chk("midrst_no_done", done, 0);
      chk("midrst_stay_idle", busy, 0);
    end
    launch(8'h03, 8'h05); collect("post_rst", 0, bc); settle("post_rst");

    chk("final_sb_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
